// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Hazard and forwarding controller for the 5-stage pipeline. It computes the
//   EX operand-forwarding selects in ID and registers them at the ID->EX
//   boundary. It also raises the load-use and HI/LO stalls and the ID/EX
//   bubble, and it tracks mul/div occupancy with a countdown FSM.
//
//   Optional feature macro: FWD_WB_BYPASS_EN
//     When defined, the regfile is read-before-write. wb_hold latches wb_data on
//     every WB write, and select 11 forwards wb_hold to EX. When undefined, the
//     regfile is write-first, 11 is never produced and wb_hold is tied to 0.
//
//   Ports
//     clk, rstn                      clock (rising edge), async active-low reset
//     id_rs, id_rt                   source registers of the instruction in ID
//     id_use_rs, id_use_rt           instruction in ID really reads rs / rt
//     id_use_hilo                    instruction in ID reads HI/LO
//     ex_rd, mem_rd, wb_rd           destination registers in EX / MEM / WB
//     ex_regwrite .. wb_regwrite     register write enables in EX / MEM / WB
//     ex_memread                     instruction in EX is a load
//     md_start                       one-cycle pulse: mul/div enters EX
//     flush                          branch/jump redirect, kills ID
//     wb_data                        WB result (bypass feature only)
//     fwd_a_sel, fwd_b_sel           registered EX operand selects
//                                    00 regfile, 01 WB, 10 MEM, 11 WB hold
//     wb_hold                        latched previous WB result
//     stall, bubble                  hold PC/IF-ID, clear ID/EX control
//     md_busy, md_done               mul/div in progress, result-valid pulse
//
//   md FSM
//     state   | meaning
//     MD_IDLE | no mul/div in flight
//     MD_BUSY | mul/div occupying EX, counter counts down to 0
//     MD_DONE | result valid this cycle (md_done pulse)

module fwd_hazard_unit #(
    parameter int MD_LATENCY = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_use_hilo,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        mem_rd,
    input  logic [4:0]        wb_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              ex_memread,
    input  logic              md_start,
    input  logic              flush,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [DATA_W-1:0] wb_hold,
    output logic              stall,
    output logic              bubble,
    output logic              md_busy,
    output logic              md_done
);

    localparam logic [5:0] MD_RELOAD = 6'(MD_LATENCY - 1);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    md_state_t  md_state, md_state_nxt;
    logic [5:0] md_cnt, md_cnt_nxt;

    logic [1:0] sel_a_comb, sel_b_comb;
    logic       load_use, hilo_stall;

    // Forwarding select for one source operand. Register 0 never matches, and
    // the youngest producer (EX, which will be in MEM next cycle) wins.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && src != 5'd0) begin
            if (ex_regwrite && ex_rd == src)
                sel = 2'b10;
            else if (mem_regwrite && mem_rd == src)
                sel = 2'b01;
`ifdef FWD_WB_BYPASS_EN
            else if (wb_regwrite && wb_rd == src)
                sel = 2'b11;
`endif
        end
        return sel;
    endfunction

    always_comb begin
        sel_a_comb = fwd_sel(id_use_rs, id_rs);
        sel_b_comb = fwd_sel(id_use_rt, id_rt);
    end

    assign load_use   = ex_memread && (ex_rd != 5'd0) &&
                        ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
    assign hilo_stall = id_use_hilo && md_busy;
    assign stall      = (load_use || hilo_stall) && !flush;
    assign bubble     = stall || flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else if (bubble) begin
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else begin
            fwd_a_sel <= sel_a_comb;
            fwd_b_sel <= sel_b_comb;
        end
    end

`ifdef FWD_WB_BYPASS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wb_hold <= '0;
        else if (wb_regwrite)
            wb_hold <= wb_data;
    end
`else
    // WB inputs only feed the bypass path; fold them here so they are visibly
    // intentionally unused in the write-first build.
    logic unused_wb;
    assign unused_wb = ^{wb_data, wb_rd, wb_regwrite};
    assign wb_hold   = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            md_state <= MD_IDLE;
            md_cnt   <= 6'd0;
        end else begin
            md_state <= md_state_nxt;
            md_cnt   <= md_cnt_nxt;
        end
    end

    always_comb begin
        md_state_nxt = md_state;
        md_cnt_nxt   = md_cnt;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        case (md_state)
            MD_IDLE: begin
                if (md_start) begin
                    md_cnt_nxt   = MD_RELOAD;
                    md_state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                // A new op replaces the one in flight.
                if (md_start)
                    md_cnt_nxt = MD_RELOAD;
                else if (md_cnt == 6'd0)
                    md_state_nxt = MD_DONE;
                else
                    md_cnt_nxt = md_cnt - 6'd1;
            end
            MD_DONE: begin
                md_done = 1'b1;
                if (md_start) begin
                    md_cnt_nxt   = MD_RELOAD;
                    md_state_nxt = MD_BUSY;
                end else begin
                    md_state_nxt = MD_IDLE;
                end
            end
            default: begin
                md_state_nxt = MD_IDLE;
                md_cnt_nxt   = 6'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int DATA_W = 32;
    localparam int MD_LAT = 4;

    logic              clk;
    logic              rstn;
    logic [4:0]        id_rs, id_rt;
    logic              id_use_rs, id_use_rt, id_use_hilo;
    logic [4:0]        ex_rd, mem_rd, wb_rd;
    logic              ex_regwrite, mem_regwrite, wb_regwrite;
    logic              ex_memread, md_start, flush;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic [DATA_W-1:0] wb_hold;
    logic              stall, bubble, md_busy, md_done;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_unit #(.MD_LATENCY(MD_LAT), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_hilo(id_use_hilo),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .md_start(md_start), .flush(flush),
        .wb_data(wb_data),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .wb_hold(wb_hold),
        .stall(stall), .bubble(bubble), .md_busy(md_busy), .md_done(md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_use_hilo = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0;
        ex_memread = 0; md_start = 0; flush = 0; wb_data = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a got=%b exp=00", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b got=%b exp=00", fwd_b_sel); end
        n_checks++; if (wb_hold !== '0) begin n_fail++; $display("FAIL reset_wb_hold got=%h exp=0", wb_hold); end
        n_checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin n_fail++; $display("FAIL reset_md got=%b%b exp=00", md_busy, md_done); end
        n_checks++; if (stall !== 1'b0 || bubble !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b%b exp=00", stall, bubble); end
        rstn = 1'b1;
        tick();
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got=%b exp=0", md_busy); end
    endtask

    task automatic test_ex_forward();
        // add r3 in EX, sub reading r3 (rs) and r3 (rt) in ID
        clear_inputs();
        ex_rd = 3; ex_regwrite = 1; id_rs = 3; id_use_rs = 1; id_rt = 3; id_use_rt = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL exfwd_stall got=%b exp=0", stall); end
        tick();
        n_checks++; if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL exfwd_a got=%b exp=10", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL exfwd_b got=%b exp=10", fwd_b_sel); end
        // MEM producer only
        clear_inputs();
        mem_rd = 3; mem_regwrite = 1; id_rs = 3; id_use_rs = 1; id_rt = 6; id_use_rt = 1;
        tick();
        n_checks++; if (fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL memfwd_a got=%b exp=01", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL memfwd_b got=%b exp=00", fwd_b_sel); end
        // match but operand not read
        clear_inputs();
        ex_rd = 3; ex_regwrite = 1; id_rs = 3; id_use_rs = 0;
        tick();
        n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL nouse_a got=%b exp=00", fwd_a_sel); end
        // match but producer not writing
        clear_inputs();
        ex_rd = 3; ex_regwrite = 0; mem_rd = 3; mem_regwrite = 0; id_rs = 3; id_use_rs = 1;
        tick();
        n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL nowrite_a got=%b exp=00", fwd_a_sel); end
    endtask

    task automatic test_priority_r0();
        clear_inputs();
        ex_rd = 4; mem_rd = 4; ex_regwrite = 1; mem_regwrite = 1; id_rt = 4; id_use_rt = 1;
        tick();
        n_checks++; if (fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL prio_b got=%b exp=10", fwd_b_sel); end
        clear_inputs();
        ex_rd = 0; ex_regwrite = 1; mem_rd = 0; mem_regwrite = 1; id_rs = 0; id_use_rs = 1; id_rt = 0; id_use_rt = 1;
        tick();
        n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL r0_a got=%b exp=00", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL r0_b got=%b exp=00", fwd_b_sel); end
    endtask

    task automatic test_load_use();
        // lw r5 in EX, add r6,r5,r7 in ID
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5;
        id_rs = 5; id_use_rs = 1; id_rt = 7; id_use_rt = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b exp=1", stall); end
        n_checks++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble got=%b exp=1", bubble); end
        tick();
        n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_a got=%b exp=00", fwd_a_sel); end
        // next cycle the load is in MEM
        clear_inputs();
        mem_rd = 5; mem_regwrite = 1; id_rs = 5; id_use_rs = 1; id_rt = 7; id_use_rt = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_next_stall got=%b exp=0", stall); end
        tick();
        n_checks++; if (fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL lu_next_a got=%b exp=01", fwd_a_sel); end
        // load-use through rt
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 8; id_rs = 2; id_use_rs = 1; id_rt = 8; id_use_rt = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_rt_stall got=%b exp=1", stall); end
        id_use_rt = 0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_rt_nouse got=%b exp=0", stall); end
        // load to r0 never stalls
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_r0 got=%b exp=0", stall); end
        // a non-load producer never stalls
        clear_inputs();
        ex_regwrite = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_nostall got=%b exp=0", stall); end
        tick();
    endtask

    task automatic test_flush();
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1; flush = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", stall); end
        n_checks++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble got=%b exp=1", bubble); end
        tick();
        n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL flush_sel got=%b exp=00", fwd_a_sel); end
        // flush alone with a forwardable match
        clear_inputs();
        ex_regwrite = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1; flush = 1;
        tick();
        n_checks++; if (fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL flush_only_b got=%b exp=00", fwd_b_sel); end
        clear_inputs();
        tick();
    endtask

    task automatic test_md_hilo();
        int busy_cnt;
        int stall_cnt;
        int done_cnt;
        int done_at;
        clear_inputs();
        id_use_hilo = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hilo_idle_stall got=%b exp=0", stall); end
        clear_inputs();
        md_start = 1;
        tick();
        md_start = 0; id_use_hilo = 1;
        busy_cnt = 0; stall_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (md_busy === 1'b1) busy_cnt++;
            if (stall === 1'b1) stall_cnt++;
            if (md_done === 1'b1) begin done_cnt++; done_at = i; end
            tick();
        end
        n_checks++; if (busy_cnt != MD_LAT) begin n_fail++; $display("FAIL md_busy_len got=%0d exp=%0d", busy_cnt, MD_LAT); end
        n_checks++; if (stall_cnt != MD_LAT) begin n_fail++; $display("FAIL hilo_stall_len got=%0d exp=%0d", stall_cnt, MD_LAT); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL md_done_cnt got=%0d exp=1", done_cnt); end
        n_checks++; if (done_at != MD_LAT) begin n_fail++; $display("FAIL md_done_pos got=%0d exp=%0d", done_at, MD_LAT); end
        clear_inputs();
    endtask

    task automatic test_md_reload();
        int busy_cnt;
        int guard;
        clear_inputs();
        md_start = 1;
        tick();
        md_start = 0;
        tick();
        // second op after two busy cycles replaces the first
        md_start = 1;
        tick();
        md_start = 0;
        busy_cnt = 3;
        guard = 0;
        while (md_busy === 1'b1 && guard < 20) begin
            tick();
            guard++;
            if (md_busy === 1'b1) busy_cnt++;
        end
        n_checks++; if (busy_cnt != 2 + MD_LAT) begin n_fail++; $display("FAIL md_reload_len got=%0d exp=%0d", busy_cnt, 2 + MD_LAT); end
        n_checks++; if (md_done !== 1'b1) begin n_fail++; $display("FAIL md_reload_done got=%b exp=1", md_done); end
        // new op accepted straight from MD_DONE
        md_start = 1;
        tick();
        md_start = 0;
        n_checks++; if (md_busy !== 1'b1 || md_done !== 1'b0) begin n_fail++; $display("FAIL md_done_restart got=%b%b exp=10", md_busy, md_done); end
        // flush does not abort the op
        flush = 1;
        tick();
        flush = 0;
        n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md_flush_keep got=%b exp=1", md_busy); end
        guard = 0;
        while (md_done !== 1'b1 && guard < 20) begin tick(); guard++; end
        n_checks++; if (guard != MD_LAT - 1) begin n_fail++; $display("FAIL md_flush_len got=%0d exp=%0d", guard, MD_LAT - 1); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        clear_inputs();
        md_start = 1;
        ex_regwrite = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
        tick();
        md_start = 0;
        tick();
        n_checks++; if (fwd_a_sel !== 2'b10 || md_busy !== 1'b1) begin n_fail++; $display("FAIL prereset got=%b/%b exp=10/1", fwd_a_sel, md_busy); end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin n_fail++; $display("FAIL async_rst_md got=%b%b exp=00", md_busy, md_done); end
        n_checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL async_rst_sel got=%b%b exp=0000", fwd_a_sel, fwd_b_sel); end
        clear_inputs();
        tick();
        rstn = 1'b1;
        tick();
        tick();
        n_checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin n_fail++; $display("FAIL rst_restart got=%b%b exp=00", md_busy, md_done); end
    endtask

    task automatic test_wb_bypass();
        clear_inputs();
        wb_rd = 9; wb_regwrite = 1; wb_data = 32'hDEADBEEF; id_rs = 9; id_use_rs = 1;
        tick();
`ifdef FWD_WB_BYPASS_EN
        n_checks++; if (fwd_a_sel !== 2'b11) begin n_fail++; $display("FAIL byp_sel got=%b exp=11", fwd_a_sel); end
        n_checks++; if (wb_hold !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byp_hold got=%h exp=deadbeef", wb_hold); end
        wb_regwrite = 0; wb_data = 32'h12345678;
        tick();
        n_checks++; if (wb_hold !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byp_hold_keep got=%h exp=deadbeef", wb_hold); end
        wb_regwrite = 1; mem_rd = 9; mem_regwrite = 1;
        tick();
        n_checks++; if (fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL byp_prio got=%b exp=01", fwd_a_sel); end
        n_checks++; if (wb_hold !== 32'h12345678) begin n_fail++; $display("FAIL byp_hold_upd got=%h exp=12345678", wb_hold); end
`else
        n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL nobyp_sel got=%b exp=00", fwd_a_sel); end
        n_checks++; if (wb_hold !== '0) begin n_fail++; $display("FAIL nobyp_hold got=%h exp=0", wb_hold); end
`endif
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_priority_r0();
        test_load_use();
        test_flush();
        test_md_hilo();
        test_md_reload();
        test_reset_mid_busy();
        test_wb_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Hazard and forwarding controller for the 5-stage pipelined CPU.
- Computes the 2-bit operand-forwarding selects in ID and registers them at the ID->EX boundary, where they drive the EX-stage mux4 operand selectors.
- Generates load-use and HI/LO stalls and the ID/EX bubble.
- Tracks multi-cycle mul/div occupancy with an internal countdown FSM.

Parameters:
- MD_LATENCY, 32, EX cycles a mul/div occupies after md_start (valid range 2..63).
- DATA_W, 32, width of the write-back data path used by the optional bypass latch.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  instruction in ID actually reads rs / rt.
- id_use_hilo  in  1  instruction in ID reads HI/LO (mfhi/mflo).
- ex_rd, mem_rd, wb_rd  in  5 each  destination register numbers in EX / MEM / WB.
- ex_regwrite, mem_regwrite, wb_regwrite  in  1 each  register write enables in EX / MEM / WB.
- ex_memread  in  1  instruction in EX is a load.
- md_start  in  1  single-cycle pulse: mul/div enters EX.
- flush  in  1  branch/jump redirect; kills the instruction in ID.
- wb_data  in  DATA_W  WB result; used only with the optional feature.
- fwd_a_sel, fwd_b_sel  out  2 each  registered EX operand selects.
  - 00: regfile.
  - 01: WB result.
  - 10: MEM ALU result.
  - 11: WB hold (optional feature only).
- wb_hold  out  DATA_W  latched previous WB result (optional feature).
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  clear ID/EX control (insert nop).
- md_busy  out  1  mul/div in progress.
- md_done  out  1  one-cycle pulse when mul/div result is valid.

Behaviour:
- Reset (rstn low, asynchronous) clears the following, and releasing reset mid-operation restarts clean:
  - fwd_a_sel and fwd_b_sel = 00.
  - wb_hold = 0.
  - md FSM returns to MD_IDLE and the counter = 0.
  - md_busy and md_done = 0.
- Combinational select, shown for rs; rt is identical. Priority runs top to bottom, and register 0 never matches:
  - 10 if ex_regwrite and ex_rd == id_rs. The EX producer will be in MEM when the consumer is in EX.
  - Otherwise 01 if mem_regwrite and mem_rd == id_rs.
  - Otherwise 00.
  - When id_use_rs = 0, the select is 00.
- Load-use stall: ex_memread and ex_rd != 0 and ((id_use_rs and ex_rd == id_rs) or (id_use_rt and ex_rd == id_rt)).
  - Lasts exactly 1 cycle.
  - The next cycle the load sits in MEM, so the recomputed select is 01.
- HI/LO stall: id_use_hilo and md_busy.
- stall = (load-use or HI/LO stall) and !flush. Flush wins over stall.
- bubble = stall or flush.
- Select registers, updated each rising edge:
  - If bubble, the registered selects become 00.
  - Otherwise they take the combinational selects.
  - Latency is 1 cycle from ID to EX.
- md FSM:
  - MD_IDLE: on md_start, load counter = MD_LATENCY-1 and go to MD_BUSY.
  - MD_BUSY: md_busy = 1 and the counter decrements. At counter 0, go to MD_DONE.
  - MD_DONE: md_done = 1 for one cycle and md_busy = 0. Go to MD_IDLE, or to MD_BUSY with counter reloaded if md_start is asserted.
  - md_start while in MD_BUSY reloads the counter (a new op replaces the old one) and stays in MD_BUSY.
  - flush does not abort an op already issued.
- Total: md_busy is high for exactly MD_LATENCY cycles after the md_start cycle.

Optional Feature:
- FWD_WB_BYPASS_EN, defined: the regfile is treated as read-before-write.
  - wb_hold captures wb_data every cycle that wb_regwrite = 1 (holds otherwise).
  - A new select value 11 has the lowest priority: wb_regwrite and wb_rd == id_rs (!= 0), with no 10/01 match.
  - In EX, mux input d3 takes wb_hold.
- FWD_WB_BYPASS_EN, undefined: the regfile is write-first.
  - 11 is never produced.
  - wb_hold is tied to 0.
  - wb_data is unused.

Test Plan:
- add r3 in EX, then sub using r3 (rs) in ID -> next cycle fwd_a_sel = 10, stall = 0.
- lw r5 in EX, then add r6,r5,r7 in ID -> stall = bubble = 1 for 1 cycle, registered sel 00. Next cycle fwd_a_sel = 01, stall = 0.
- ex_rd = mem_rd = 4, both regwrite, id_rt = 4 -> fwd_b_sel = 10 (MEM priority). With ex_rd = 0 writing, id_rs = 0 -> sel 00.
- md_start pulse with MD_LATENCY = 4, mfhi in ID next cycle:
  - md_busy high for 4 cycles, then md_done pulses once.
  - stall high for 4 cycles, then mfhi proceeds.
- Load-use condition with flush = 1 in the same cycle -> stall = 0, bubble = 1, sel 00.
- rstn low during MD_BUSY (counter 2) -> md_busy, md_done and selects are 0 immediately.
- With FWD_WB_BYPASS_EN: wb_rd = 9, wb_data = 0xDEADBEEF, id_rs = 9, no other match -> next cycle fwd_a_sel = 11, wb_hold = 0xDEADBEEF.
